// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the pwm fade sequencer and its period counter.
//
// Contents:
//   DEFAULT_CTR_LEN  - default pwm counter / level width
//   DEFAULT_RATE_LEN - default periods-per-step field width
//   state_t          - sequencer state encoding (ST_IDLE, ST_RUN)
//
// Abort priority: in ST_RUN an asserted abort wins over any step that would
// otherwise happen on the same wrap edge, so the level is left untouched.
package pwm_fade_ctrl_pkg;

  localparam int DEFAULT_CTR_LEN  = 8;
  localparam int DEFAULT_RATE_LEN = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_period_ctr.sv
// Free-running shadow of the pwm counter.
//
// Reset together with the pwm instance so both counters stay phase-locked.
// The counter runs 0 .. 2^CTR_LEN-1 and wraps; period_start marks the last
// cycle of a pwm period, i.e. the clock edge that follows it is the wrap edge.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ctr          out  current counter value
//   period_start out  high while ctr is all-ones
module pwm_period_ctr
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int CTR_LEN = DEFAULT_CTR_LEN
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CTR_LEN-1:0] ctr,
  output logic               period_start
);

  logic [CTR_LEN-1:0] r_ctr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr <= '0;
    end else begin
      r_ctr <= r_ctr + 1'b1;
    end
  end

  assign ctr          = r_ctr;
  assign period_start = &r_ctr;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-level fade sequencer feeding the compare input of a pwm instance.
//
// A command (target, step, rate) is accepted in IDLE. In RUN the level moves
// toward the target by at most step every (rate+1) pwm periods; the level
// only ever changes on a wrap edge (ctr all-ones -> 0), so the pwm output
// never sees a mid-period compare change.
//
// Optional feature macro: PWM_FADE_GAMMA_EN
//   defined   - compare is (level*level) >> CTR_LEN, registered one cycle
//               after the level update; done is delayed to match.
//   undefined - compare is the level register itself.
//
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_valid
// is ignored while it is low.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cmd_valid     command offer
//   cmd_ready     command can be accepted (IDLE)
//   cmd_target    final level
//   cmd_step      level change per step (0 behaves as 1)
//   cmd_rate      pwm periods per step minus 1
//   abort         stop the ramp, hold the current level
//   compare       to pwm.compare
//   busy          ramp in progress
//   done          one-cycle pulse when the target is reached
//   period_start  last cycle of a pwm period
//   dbg_state     current sequencer state
//   dbg_ctr       shadow counter value
module pwm_fade_ctrl
  import pwm_fade_ctrl_pkg::*;
#(
  parameter int CTR_LEN  = DEFAULT_CTR_LEN,
  parameter int RATE_LEN = DEFAULT_RATE_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CTR_LEN-1:0]  cmd_target,
  input  logic [CTR_LEN-1:0]  cmd_step,
  input  logic [RATE_LEN-1:0] cmd_rate,
  input  logic                abort,
  output logic [CTR_LEN-1:0]  compare,
  output logic                busy,
  output logic                done,
  output logic                period_start,
  output state_t              dbg_state,
  output logic [CTR_LEN-1:0]  dbg_ctr
);

  // ---------------------------------------------------------------------
  // Shadow counter
  // ---------------------------------------------------------------------
  logic               w_period_start;
  logic [CTR_LEN-1:0] w_ctr;

  pwm_period_ctr #(
    .CTR_LEN(CTR_LEN)
  ) u_period_ctr (
    .clk         (clk),
    .rst         (rst),
    .ctr         (w_ctr),
    .period_start(w_period_start)
  );

  // The edge following period_start is the wrap edge.
  logic w_wrap;
  assign w_wrap = w_period_start;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t              r_state;
  logic [CTR_LEN-1:0]  r_level;
  logic [CTR_LEN-1:0]  r_target;
  logic [CTR_LEN-1:0]  r_step;
  logic [RATE_LEN-1:0] r_rate;
  logic [RATE_LEN-1:0] r_rate_cnt;
  logic                r_done;

  state_t              w_state_nxt;
  logic [CTR_LEN-1:0]  w_level_nxt;
  logic [CTR_LEN-1:0]  w_target_nxt;
  logic [CTR_LEN-1:0]  w_step_nxt;
  logic [RATE_LEN-1:0] w_rate_nxt;
  logic [RATE_LEN-1:0] w_rate_cnt_nxt;
  logic                w_done_nxt;

  // ---------------------------------------------------------------------
  // Saturating step toward target, evaluated one bit wider than the level
  // ---------------------------------------------------------------------
  logic               w_up;
  logic [CTR_LEN:0]   w_diff;
  logic               w_near;
  logic [CTR_LEN:0]   w_moved;
  logic [CTR_LEN-1:0] w_step_level;

  assign w_up   = (r_target >= r_level);
  assign w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_level})
                       : ({1'b0, r_level}  - {1'b0, r_target});
  assign w_near = (w_diff <= {1'b0, r_step});

  assign w_moved = w_up ? ({1'b0, r_level} + {1'b0, r_step})
                        : ({1'b0, r_level} - {1'b0, r_step});

  // Carry/borrow out of the wide result clamps to the rail; when the target
  // is within one step the level lands exactly on it.
  always_comb begin
    w_step_level = w_moved[CTR_LEN-1:0];
    if (w_near) begin
      w_step_level = r_target;
    end else if (w_moved[CTR_LEN]) begin
      w_step_level = w_up ? '1 : '0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_level    <= '0;
      r_target   <= '0;
      r_step     <= '0;
      r_rate     <= '0;
      r_rate_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_target   <= w_target_nxt;
      r_step     <= w_step_nxt;
      r_rate     <= w_rate_nxt;
      r_rate_cnt <= w_rate_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_level_nxt    = r_level;
    w_target_nxt   = r_target;
    w_step_nxt     = r_step;
    w_rate_nxt     = r_rate;
    w_rate_cnt_nxt = r_rate_cnt;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Acceptance never moves the level, even on a wrap edge.
        if (cmd_valid) begin
          w_target_nxt   = cmd_target;
          w_step_nxt     = (cmd_step == '0) ? {{(CTR_LEN-1){1'b0}}, 1'b1} : cmd_step;
          w_rate_nxt     = cmd_rate;
          w_rate_cnt_nxt = cmd_rate;
          w_state_nxt    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_wrap) begin
          if (r_rate_cnt != '0) begin
            w_rate_cnt_nxt = r_rate_cnt - 1'b1;
          end else begin
            w_rate_cnt_nxt = r_rate;
            w_level_nxt    = w_step_level;
            if (w_step_level == r_target) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cmd_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state == ST_RUN);
  assign period_start = w_period_start;
  assign dbg_state    = r_state;
  assign dbg_ctr      = w_ctr;

`ifdef PWM_FADE_GAMMA_EN
  // Gamma-2 curve; lands one cycle after the wrap edge, when the pwm
  // counter is at 1, so done is delayed by the same cycle.
  logic [2*CTR_LEN-1:0] w_sq;
  logic [CTR_LEN-1:0]   w_gamma;
  logic [CTR_LEN-1:0]   r_gamma;
  logic                 r_done_d;

  assign w_sq    = r_level * r_level;
  assign w_gamma = CTR_LEN'(w_sq >> CTR_LEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gamma  <= '0;
      r_done_d <= 1'b0;
    end else begin
      r_gamma  <= w_gamma;
      r_done_d <= r_done;
    end
  end

  assign compare = r_gamma;
  assign done    = r_done_d;
`else
  assign compare = r_level;
  assign done    = r_done;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Testbench for pwm_fade_ctrl (CTR_LEN=8, RATE_LEN=8).
// Scoreboard entries are {is_done, wrap_no, compare_value}: wrap_no counts
// wrap edges since the most recent command acceptance.
module tb_pwm_fade_ctrl;
  import pwm_fade_ctrl_pkg::*;

  localparam int CTR_LEN  = 8;
  localparam int RATE_LEN = 8;
`ifdef PWM_FADE_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [CTR_LEN-1:0]  cmd_target = '0;
  logic [CTR_LEN-1:0]  cmd_step = '0;
  logic [RATE_LEN-1:0] cmd_rate = '0;
  logic                abort = 1'b0;
  logic [CTR_LEN-1:0]  compare;
  logic                busy;
  logic                done;
  logic                period_start;
  state_t              dbg_state;
  logic [CTR_LEN-1:0]  dbg_ctr;

  pwm_fade_ctrl #(
    .CTR_LEN (CTR_LEN),
    .RATE_LEN(RATE_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_rate    (cmd_rate),
    .abort       (abort),
    .compare     (compare),
    .busy        (busy),
    .done        (done),
    .period_start(period_start),
    .dbg_state   (dbg_state),
    .dbg_ctr     (dbg_ctr)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [16:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  m_cmp    = '0;   // model of the last expected compare value

  function automatic logic [7:0] exp_cmp(input int lvl);
    if (GAMMA) return 8'((lvl * lvl) >> 8);
    else       return 8'(lvl);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Expect the level to become lvl at wrap number w (no event if the
  // visible compare value would not change).
  task automatic exp_level(input int lvl, input int w);
    logic [7:0] c;
    c = exp_cmp(lvl);
    if (c != m_cmp) exp_q.push_back({1'b0, 8'(w), c});
    m_cmp = c;
  endtask

  task automatic exp_done(input int lvl, input int w);
    exp_q.push_back({1'b1, 8'(w), exp_cmp(lvl)});
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  logic [7:0]  prev_cmp = '0;
  logic        ps_h1 = 1'b0;
  logic        ps_h2 = 1'b0;
  int          wrap_cnt = 0;
  logic [16:0] it;

  always @(negedge clk) begin
    if (rst) begin
      prev_cmp = compare;
      ps_h1    = 1'b0;
      ps_h2    = 1'b0;
      wrap_cnt = 0;
    end else begin
      if (compare != prev_cmp) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cmp_unexpected actual=%0d expected=none t=%0t", compare, $time);
        end else begin
          it = exp_q.pop_front();
          if (it[16] || it[7:0] != compare || int'(it[15:8]) != wrap_cnt) begin
            failures++;
            $display("FAIL cmp_event actual=cmp%0d/wrap%0d/done0 expected=cmp%0d/wrap%0d/done%0d t=%0t",
                     compare, wrap_cnt, it[7:0], it[15:8], it[16], $time);
          end
        end
        chk("cmp_on_wrap", int'(GAMMA ? ps_h2 : ps_h1), 1);
        prev_cmp = compare;
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected actual=1 expected=0 t=%0t", $time);
        end else begin
          it = exp_q.pop_front();
          if (!it[16] || it[7:0] != compare || int'(it[15:8]) != wrap_cnt) begin
            failures++;
            $display("FAIL done_event actual=cmp%0d/wrap%0d/done1 expected=cmp%0d/wrap%0d/done%0d t=%0t",
                     compare, wrap_cnt, it[7:0], it[15:8], it[16], $time);
          end
        end
        chk("done_busy", int'(busy), 0);
        chk("done_ready", int'(cmd_ready), 1);
      end
      ps_h2 = ps_h1;
      ps_h1 = period_start;
      if (cmd_valid && cmd_ready) wrap_cnt = 0;
      else if (period_start)      wrap_cnt++;
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------
  task automatic send_cmd(input int t, input int s, input int r);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (!ok) chk("cmd_ready_timeout", 0, 1);
    cmd_valid  = 1'b1;
    cmd_target = 8'(t);
    cmd_step   = 8'(s);
    cmd_rate   = 8'(r);
    @(posedge clk); #2;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (cmd_ready && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_cmp(input int lvl, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (compare == exp_cmp(lvl)) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input string name);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk({name, "_rst_compare"}, int'(compare), 0);
    chk({name, "_rst_busy"}, int'(busy), 0);
    chk({name, "_rst_ready"}, int'(cmd_ready), 1);
    exp_q.delete();
    m_cmp = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_compare", int'(compare), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_period_start", int'(period_start), 0);
    chk("reset_ctr", int'(dbg_ctr), 0);
    chk("reset_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;

    // Ramp up 0 -> 128, step 32, one period per step
    exp_level(32, 1); exp_level(64, 2); exp_level(96, 3); exp_level(128, 4);
    exp_done(128, 4);
    send_cmd(128, 32, 0);
    chk("ramp_busy", int'(busy), 1);
    chk("ramp_ready", int'(cmd_ready), 0);
    wait_idle("ramp_up");
    chk("ramp_end_busy", int'(busy), 0);
    chk("ramp_end_ready", int'(cmd_ready), 1);

    // Command offered while busy is ignored
    exp_level(192, 1); exp_level(255, 2); exp_done(255, 2);
    send_cmd(255, 64, 0);
    repeat (20) @(posedge clk);
    #2;
    chk("ignore_ready_low", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_target = 8'd0; cmd_step = 8'd1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    wait_idle("ignore");
    chk("ignore_final", int'(compare), int'(exp_cmp(255)));

    // Asynchronous reset in the middle of a ramp
    exp_level(254, 1);
    send_cmd(0, 1, 0);
    wait_cmp(254, "mid_ramp");
    repeat (7) @(posedge clk);
    do_reset("async");

    // Saturating step: 0 -> 100 with step 32
    exp_level(32, 1); exp_level(64, 2); exp_level(96, 3); exp_level(100, 4);
    exp_done(100, 4);
    send_cmd(100, 32, 0);
    wait_idle("sat_up");
    // 100 -> 30, step 50, two periods per step
    exp_level(50, 2); exp_level(30, 4); exp_done(30, 4);
    send_cmd(30, 50, 1);
    wait_idle("sat_down");

    // Abort mid-period, then immediate new command
    do_reset("pre_abort");
    exp_level(32, 1); exp_level(64, 2);
    send_cmd(128, 32, 0);
    wait_cmp(64, "abort_wait");
    repeat (10) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_state", int'(dbg_state), int'(ST_IDLE));
    chk("abort_hold", int'(compare), int'(exp_cmp(64)));
    exp_level(74, 1);
    send_cmd(200, 10, 0);
    wait_cmp(74, "abort2_wait");
    // Abort sampled on a step wrap edge: level must not move
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #2;
        if (period_start) begin ok = 1'b1; break; end
      end
      if (!ok) chk("abort_wrap_timeout", 0, 1);
    end
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    repeat (600) @(posedge clk);
    #2;
    chk("abort_wrap_hold", int'(compare), int'(exp_cmp(74)));
    chk("abort_wrap_state", int'(dbg_state), int'(ST_IDLE));

    // Degenerate cases: 74 -> 10, then step 0 to 12, then target == level
    exp_level(10, 1); exp_done(10, 1);
    send_cmd(10, 64, 0);
    wait_idle("to_ten");
    exp_level(11, 1); exp_level(12, 2); exp_done(12, 2);
    send_cmd(12, 0, 0);
    wait_idle("step_zero");
    exp_done(12, 4);
    send_cmd(12, 5, 3);
    wait_idle("same_level");

    // Large single steps (gamma-corrected when the feature is built in)
    exp_level(128, 1); exp_done(128, 1);
    send_cmd(128, 116, 0);
    wait_idle("to_128");
    exp_level(255, 1); exp_done(255, 1);
    send_cmd(255, 127, 0);
    wait_idle("to_255");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
